ospfb_frame_capture: RTL and testbench
======================================

OSPFB_FRAME_CAPTURE -- requirements
Module: ospfb_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per real/imag component; tdata is 2*WIDTH as {im, re}, both signed.
REQ-002 SHALL have parameter FFT_LEN, default 64: bins per frame, power of two, 8..4096.
REQ-003 SHALL have parameter TUSER_WID, default 8: input tuser width.
REQ-004 SHALL have ports, one per line:
- clk  input  1  sole clock; all logic on its rising edge.
- aresetn  input  1  reset, asynchronous, active-low.
- s_axis  axis.SLV  2*WIDTH  OSPFB FFT output (tdata/tvalid/tready).
- s_axis_tlast  input  1  last bin of a frame.
- s_axis_tuser  input  TUSER_WID  FFT tuser, captured with bin 0.
- arm  input  1  one-cycle request to capture the next aligned frame.
- m_axis  axis.MST  2*WIDTH  readout of the captured frame.
- m_axis_tlast  output  1  readout beat FFT_LEN-1.
- busy  output  1  state is not IDLE.
- done  output  1  a captured frame is fully drained.
- frame_tuser  output  TUSER_WID  tuser of the captured bin 0.
- frame_cnt  output  32  aligned frames seen since reset, wrapping.
- err_tlast_early  output  1  sticky: tlast seen before bin FFT_LEN-1.
- err_tlast_late  output  1  sticky: no tlast at bin FFT_LEN-1.
- peak_bin  output  $clog2(FFT_LEN)  bin of maximum power.
- peak_pwr  output  2*WIDTH  unsigned maximum re^2+im^2.

Function
REQ-005 SHALL hold s_axis.tready=1 in every state; data is consumed or discarded, never back-pressured, so the OSPFB FFT never halts.
REQ-006 SHALL implement states IDLE, SYNC, CAPTURE, DRAIN.
REQ-007 IDLE: discard input; arm -> SYNC, clear done, clear peak registers.
REQ-008 SYNC: discard input; an accepted beat with tlast=1 -> CAPTURE, so the next accepted beat is bin 0.
REQ-009 CAPTURE: write each accepted beat to the internal buffer at a bin index starting at 0.
REQ-010 CAPTURE: latch s_axis_tuser on bin 0 into frame_tuser.
REQ-011 CAPTURE: bin FFT_LEN-1 accepted with tlast=1 -> DRAIN.
REQ-012 CAPTURE: tlast at bin k<FFT_LEN-1 -> set err_tlast_early; restart the index at 0 on the next beat and stay in CAPTURE.
REQ-013 CAPTURE: bin FFT_LEN-1 with tlast=0 -> set err_tlast_late; discard the frame and return to SYNC.
REQ-014 DRAIN: present bins 0..FFT_LEN-1 in order on m_axis, assert m_axis_tlast on bin FFT_LEN-1, and continue discarding input.
REQ-015 DRAIN: first m_axis.tvalid SHALL rise at most 2 cycles after entry.
REQ-016 m_axis: tdata and tlast SHALL stay stable while tvalid=1 and tready=0; no bubbles while tready=1.
REQ-017 DRAIN: last beat accepted -> IDLE, set done, leaving done high until the next accepted arm.
REQ-018 SHALL ignore arm outside IDLE.
REQ-019 SHALL increment frame_cnt on every accepted tlast in any state except the abort case of REQ-012.
REQ-020 Error flags SHALL clear only on reset.

Reset
REQ-021 aresetn low SHALL immediately force state IDLE, m_axis.tvalid=0, m_axis_tlast=0, done=0, and zero on frame_tuser, frame_cnt, both error flags, peak_bin and peak_pwr.
REQ-022 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the frame; buffer contents need not be cleared.

Configuration
REQ-023 Macro OSPFB_CAPTURE_PEAK_EN defined: during CAPTURE, compute pwr=re*re+im*im per beat in 2*WIDTH unsigned bits, saturating at all-ones.
REQ-024 With the macro defined, peak_pwr/peak_bin SHALL update when pwr > peak_pwr (ties keep the lowest bin); final values are valid when DRAIN is entered, and the pipeline latency of the computation is at most 2 cycles.
REQ-025 Macro undefined: peak_bin and peak_pwr SHALL be constant 0 and no multipliers SHALL be synthesized.

Structure
REQ-026 Package ospfb_capture_pkg SHALL hold the state enum typedef and the complex {im, re} sample struct typedef.
REQ-027 The buffer SHALL be a sub-module capture_ram: simple dual-port, FFT_LEN x 2*WIDTH, one write port, one read port with 1-cycle registered read.

Verification
REQ-028 Reset, arm, then 3 frames of 64 beats with tlast on beat 63 -> first frame discarded in SYNC, second captured and drained bit-exact, tlast on readout beat 63, done=1, frame_cnt=3.
REQ-029 With the macro defined: captured frame all zero except bin 5 = {im=0, re=100} -> peak_bin=5, peak_pwr=10000; bins 5 and 9 equal -> peak_bin=5.
REQ-030 Readout with m_axis.tready toggling randomly at 50% -> 64 beats in order, no duplicates or drops, data stable while stalled.
REQ-031 tlast injected at capture bin 20 -> err_tlast_early=1, the following 64-beat frame captured correctly.
REQ-032 Frame missing tlast at bin 63 -> err_tlast_late=1, return to SYNC, next aligned frame captured.
REQ-033 aresetn low at capture bin 30 -> all outputs at reset values; arm after release -> normal capture.

Source files
------------

// File: rtl/ospfb_capture_pkg.sv
// ospfb_capture_pkg -- shared types for the OSPFB frame-capture block.
//   cap_state_e : capture FSM state encoding.
//   cpx_t       : one complex FFT bin as carried on tdata, {im, re}, both
//                 signed, at the default component width CPX_W.
package ospfb_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_e;

  localparam int CPX_W = 16;

  typedef struct packed {
    logic signed [CPX_W-1:0] im;
    logic signed [CPX_W-1:0] re;
  } cpx_t;

endpackage

// File: rtl/ospfb_frame_capture_ram.sv
// capture_ram -- frame buffer, simple dual-port, DEPTH x DW.
//   clk_i                    : clock
//   we_i / waddr_i / wdata_i : write port
//   re_i / raddr_i           : read request
//   rdata_o                  : registered read data, valid the cycle after
//                              re_i; holds its value while re_i is low.
module capture_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ospfb_frame_capture.sv
// ospfb_frame_capture -- grabs one tlast-aligned frame from the OSPFB FFT
// output stream and replays it on m_axis.
//   clk, aresetn                 : clock, async active-low reset
//   s_axis_* (+tlast, tuser)     : FFT stream, tready tied high
//   arm                          : request capture of the next aligned frame
//   m_axis_* (+tlast)            : readout of the captured frame
//   busy, done                   : status
//   frame_tuser, frame_cnt       : tuser of bin 0, aligned-frame counter
//   err_tlast_early/late         : sticky framing errors
//   peak_bin, peak_pwr           : max-power bin (macro OSPFB_CAPTURE_PEAK_EN)
module ospfb_frame_capture
  import ospfb_capture_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FFT_LEN   = 64,
  parameter int TUSER_WID = 8
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [2*WIDTH-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [TUSER_WID-1:0]       s_axis_tuser,
  input  logic                       arm,
  output logic [2*WIDTH-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       done,
  output logic [TUSER_WID-1:0]       frame_tuser,
  output logic [31:0]                frame_cnt,
  output logic                       err_tlast_early,
  output logic                       err_tlast_late,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin,
  output logic [2*WIDTH-1:0]         peak_pwr
);

  localparam int AW = $clog2(FFT_LEN);
  localparam int DW = 2*WIDTH;
  localparam logic [AW-1:0] LAST_BIN = AW'(FFT_LEN-1);
  localparam logic [AW:0]   RD_END   = (AW+1)'(FFT_LEN);
  localparam logic [AW:0]   RD_LAST  = (AW+1)'(FFT_LEN-1);

  cap_state_e           state_q;
  logic [AW-1:0]        bin_q;
  logic [AW:0]          rd_ptr_q;
  logic                 m_vld_q, m_last_q, done_q, err_e_q, err_l_q;
  logic [TUSER_WID-1:0] tuser_q;
  logic [31:0]          cnt_q;

  logic wr_en, rd_fire, bin_last, early_abort;

  assign s_axis_tready = 1'b1;
  assign bin_last      = (bin_q == LAST_BIN);
  assign wr_en         = (state_q == ST_CAPTURE) && s_axis_tvalid;
  // An early tlast inside a capture aborts the partial frame and is not
  // an aligned frame boundary, so it is kept out of frame_cnt.
  assign early_abort   = (state_q == ST_CAPTURE) && !bin_last;
  // Fetch the next bin whenever the output register is empty or draining.
  assign rd_fire       = (state_q == ST_DRAIN) && (rd_ptr_q != RD_END) &&
                         (!m_vld_q || m_axis_tready);

  capture_ram #(.DW(DW), .DEPTH(FFT_LEN)) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (bin_q),
    .wdata_i (s_axis_tdata),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (m_axis_tdata)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      rd_ptr_q <= '0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      done_q   <= 1'b0;
      err_e_q  <= 1'b0;
      err_l_q  <= 1'b0;
      tuser_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (s_axis_tvalid && s_axis_tlast && !early_abort) cnt_q <= cnt_q + 32'd1;
      case (state_q)
        ST_IDLE: if (arm) begin
          state_q <= ST_SYNC;
          done_q  <= 1'b0;
        end
        ST_SYNC: if (s_axis_tvalid && s_axis_tlast) begin
          state_q <= ST_CAPTURE;
          bin_q   <= '0;
        end
        ST_CAPTURE: if (s_axis_tvalid) begin
          if (bin_q == '0) tuser_q <= s_axis_tuser;
          if (bin_last) begin
            bin_q <= '0;
            if (s_axis_tlast) begin
              state_q  <= ST_DRAIN;
              rd_ptr_q <= '0;
            end else begin
              err_l_q <= 1'b1;
              state_q <= ST_SYNC;
            end
          end else if (s_axis_tlast) begin
            err_e_q <= 1'b1;
            bin_q   <= '0;
          end else begin
            bin_q <= bin_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            m_vld_q  <= 1'b1;
            m_last_q <= (rd_ptr_q == RD_LAST);
          end else if (m_axis_tready) begin
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
          end
          if (m_vld_q && m_axis_tready && m_last_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid   = m_vld_q;
  assign m_axis_tlast    = m_last_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign frame_tuser     = tuser_q;
  assign frame_cnt       = cnt_q;
  assign err_tlast_early = err_e_q;
  assign err_tlast_late  = err_l_q;

`ifdef OSPFB_CAPTURE_PEAK_EN
  logic signed [WIDTH-1:0] s_re, s_im;
  logic signed [DW-1:0]    re_sq, im_sq;
  logic [DW:0]             pwr_sum;
  logic [DW-1:0]           pwr;
  logic [AW-1:0]           pk_bin_q;
  logic [DW-1:0]           pk_pwr_q;

  assign s_re    = s_axis_tdata[WIDTH-1:0];
  assign s_im    = s_axis_tdata[DW-1:WIDTH];
  assign re_sq   = DW'(s_re) * DW'(s_re);
  assign im_sq   = DW'(s_im) * DW'(s_im);
  assign pwr_sum = {1'b0, re_sq} + {1'b0, im_sq};
  assign pwr     = pwr_sum[DW] ? '1 : pwr_sum[DW-1:0];

  // Bin 0 loads unconditionally so a restarted or re-synced frame never
  // inherits the peak of an abandoned one; strict > keeps the lowest bin.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pk_bin_q <= '0;
      pk_pwr_q <= '0;
    end else if (state_q == ST_IDLE && arm) begin
      pk_bin_q <= '0;
      pk_pwr_q <= '0;
    end else if (wr_en && (bin_q == '0 || pwr > pk_pwr_q)) begin
      pk_bin_q <= bin_q;
      pk_pwr_q <= pwr;
    end
  end

  assign peak_bin = pk_bin_q;
  assign peak_pwr = pk_pwr_q;
`else
  assign peak_bin = '0;
  assign peak_pwr = '0;
`endif

endmodule

// File: tb/tb_ospfb_frame_capture.sv
module tb_ospfb_frame_capture;
  import ospfb_capture_pkg::*;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int TU = 8;
  localparam int AW = 6;
  localparam int DW = 2*W;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [TU-1:0] s_tuser = '0;
  logic          arm = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready = 1'b0;
  logic          busy, done, err_e, err_l;
  logic [TU-1:0] f_tuser;
  logic [31:0]   f_cnt;
  logic [AW-1:0] pk_bin;
  logic [DW-1:0] pk_pwr;

  ospfb_frame_capture #(.WIDTH(W), .FFT_LEN(N), .TUSER_WID(TU)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .arm(arm),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .busy(busy), .done(done), .frame_tuser(f_tuser),
    .frame_cnt(f_cnt), .err_tlast_early(err_e), .err_tlast_late(err_l),
    .peak_bin(pk_bin), .peak_pwr(pk_pwr)
  );

  int n_chk = 0, n_fail = 0;
  cpx_t          exp_frame [N];
  logic [TU-1:0] exp_tuser;
  int unsigned   exp_cnt = 0;
  bit            exp_ee = 0, exp_el = 0, gaps = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
    check({tag, "_tlast"},  64'(m_tlast),  64'(0));
    check({tag, "_busy"},   64'(busy),     64'(0));
    check({tag, "_done"},   64'(done),     64'(0));
    check({tag, "_tuser"},  64'(f_tuser),  64'(0));
    check({tag, "_cnt"},    64'(f_cnt),    64'(0));
    check({tag, "_err_e"},  64'(err_e),    64'(0));
    check({tag, "_err_l"},  64'(err_l),    64'(0));
    check({tag, "_pkbin"},  64'(pk_bin),   64'(0));
    check({tag, "_pkpwr"},  64'(pk_pwr),   64'(0));
    check({tag, "_sready"}, 64'(s_tready), 64'(1));
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last, input logic [TU-1:0] u);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
    end
    @(negedge clk);
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last; s_tuser = u;
  endtask

  task automatic idle_in();
    @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // mode 0: random bins; 1: zero except bin5 re=100; 2: also bin9 im=-100
  task automatic send_frame(input int n, input int tl_at, input bit counted,
                            input bit keep, input int mode);
    cpx_t c;
    logic [TU-1:0] u;
    for (int b = 0; b < n; b++) begin
      c = cpx_t'($urandom);
      u = TU'($urandom);
      if (mode != 0) c = '0;
      if (mode != 0 && b == 5) c.re = 16'sd100;
      if (mode == 2 && b == 9) c.im = -16'sd100;
      if (keep) begin
        exp_frame[b] = c;
        if (b == 0) exp_tuser = u;
      end
      beat(c, b == tl_at, u);
    end
    if (tl_at >= 0 && counted) exp_cnt++;
  endtask

  task automatic do_arm();
    @(negedge clk); arm = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic model_peak(output int bi, output longint bp);
    longint p;
    bp = -1; bi = 0;
    for (int i = 0; i < N; i++) begin
      p = longint'(exp_frame[i].re) * exp_frame[i].re +
          longint'(exp_frame[i].im) * exp_frame[i].im;
      if (p > bp) begin bp = p; bi = i; end
    end
  endtask

  task automatic drain_check(input string tag);
    logic [DW-1:0] got [$];
    logic [DW-1:0] pd;
    logic          pl, rdy;
    bit            stall = 0, hs = 0;
    int            cyc = 0, pb;
    longint        pp;
    while (got.size() < N && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (stall) begin
        check({tag, "_stall_vld"},  64'(m_tvalid), 64'(1));
        check({tag, "_stall_data"}, 64'(m_tdata),  64'(pd));
        check({tag, "_stall_last"}, 64'(m_tlast),  64'(pl));
      end
      if (hs) check({tag, "_no_bubble"}, 64'(m_tvalid), 64'(1));
      rdy = 1'($urandom_range(0, 1));
      m_tready = rdy;
      s_tvalid = 1'($urandom_range(0, 1)); s_tdata = $urandom; s_tlast = 1'b0;
      hs = m_tvalid && rdy;
      stall = m_tvalid && !rdy;
      pd = m_tdata; pl = m_tlast;
      if (hs) begin
        got.push_back(m_tdata);
        check({tag, "_rd_last"}, 64'(m_tlast), 64'(got.size() == N));
      end
    end
    check({tag, "_beats"}, 64'(got.size()), 64'(N));
    @(negedge clk); m_tready = 1'b0; s_tvalid = 1'b0;
    check({tag, "_done"},   64'(done),     64'(1));
    check({tag, "_busy"},   64'(busy),     64'(0));
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
    for (int i = 0; i < got.size(); i++)
      check($sformatf("%s_bin%0d", tag, i), 64'(got[i]), 64'(exp_frame[i]));
    check({tag, "_tuser"}, 64'(f_tuser), 64'(exp_tuser));
    check({tag, "_cnt"},   64'(f_cnt),   64'(exp_cnt));
    check({tag, "_err_e"}, 64'(err_e),   64'(exp_ee));
    check({tag, "_err_l"}, 64'(err_l),   64'(exp_el));
`ifdef OSPFB_CAPTURE_PEAK_EN
    model_peak(pb, pp);
    check({tag, "_pkbin"}, 64'(pk_bin), 64'(pb));
    check({tag, "_pkpwr"}, 64'(pk_pwr), 64'(pp));
`else
    check({tag, "_pkbin"}, 64'(pk_bin), 64'(0));
    check({tag, "_pkpwr"}, 64'(pk_pwr), 64'(0));
`endif
  endtask

  task automatic arm_and_check(input string tag);
    do_arm();
    check({tag, "_arm_busy"},  64'(busy),   64'(1));
    check({tag, "_arm_done"},  64'(done),   64'(0));
    check({tag, "_arm_pkpwr"}, 64'(pk_pwr), 64'(0));
  endtask

  initial begin
    // reset state
    #12 chk_reset_vals("rst");
    @(negedge clk); aresetn = 1'b1;
    @(negedge clk); chk_reset_vals("post_rst");

    // three back-to-back frames: sync, capture, discarded during stalled drain
    arm_and_check("f3");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, N-1, 1, 1, 0);
    idle_in(); idle_in(); idle_in();
    check("drain_latency", 64'(m_tvalid), 64'(1));
    send_frame(N, N-1, 1, 0, 0);
    do_arm();  // ignored outside IDLE
    check("f3_busy_drain", 64'(busy), 64'(1));
    drain_check("f3");
    check("f3_cnt3", 64'(f_cnt), 64'(3));

    // early tlast at capture bin 20
    arm_and_check("early");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(21, 20, 0, 0, 0);
    exp_ee = 1;
    send_frame(N, N-1, 1, 1, 0);
    drain_check("early");

    // missing tlast at bin 63
    arm_and_check("late");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, -1, 0, 0, 0);
    exp_el = 1;
    idle_in();
    check("late_err_now", 64'(err_l), 64'(1));
    check("late_busy", 64'(busy), 64'(1));
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, N-1, 1, 1, 0);
    drain_check("late");

    // peak frames (peak expectations come from the model / zero if disabled)
    arm_and_check("pk1");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, N-1, 1, 1, 1);
    drain_check("pk1");
`ifdef OSPFB_CAPTURE_PEAK_EN
    check("pk1_bin5", 64'(pk_bin), 64'(5));
    check("pk1_pwr10000", 64'(pk_pwr), 64'(10000));
`endif
    arm_and_check("pk2");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, N-1, 1, 1, 2);
    drain_check("pk2");
`ifdef OSPFB_CAPTURE_PEAK_EN
    check("pk2_tie_bin5", 64'(pk_bin), 64'(5));
`endif

    // reset in the middle of a capture
    arm_and_check("mrst");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(30, -1, 0, 0, 0);
    @(negedge clk);
    s_tdata = $urandom; s_tvalid = 1'b1; s_tlast = 1'b0; aresetn = 1'b0;
    #1 chk_reset_vals("mrst");
    @(negedge clk); aresetn = 1'b1; s_tvalid = 1'b0;
    exp_cnt = 0; exp_ee = 0; exp_el = 0;
    arm_and_check("mrst2");
    send_frame(N, N-1, 1, 0, 0);
    send_frame(N, N-1, 1, 1, 0);
    drain_check("mrst2");

    // random captures with gapped input
    gaps = 1;
    for (int k = 0; k < 2; k++) begin
      arm_and_check("rnd");
      send_frame(N, N-1, 1, 0, 0);
      send_frame(N, N-1, 1, 1, 0);
      drain_check($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
